// File: rtl/apb_master_arbiter_pkg.sv
// Shared types and constants for the two-master APB arbiter.
// FSM encodings are fixed so that state dumps read the same across tools.
package apb_master_arbiter_pkg;
   localparam int NUM_MASTERS = 2;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_SETUP  = 2'b01,
      ST_ACCESS = 2'b10
   } apb_state_t;
endpackage

// File: rtl/apb_master_arbiter_if.sv
// Requester-side and APB-side signals of the arbiter, bundled for port connection.
// "master" is the arbiter's view; "slave" is the view of the surrounding masters and APB slave.
interface apb_master_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   import apb_master_arbiter_pkg::*;

   logic [NUM_MASTERS-1:0]             m_req;
   logic [NUM_MASTERS-1:0]             m_write;
   logic [NUM_MASTERS-1:0][ADDR_W-1:0] m_addr;
   logic [NUM_MASTERS-1:0][DATA_W-1:0] m_wdata;
   logic [NUM_MASTERS-1:0]             m_done;
   logic [DATA_W-1:0]                  m_rdata;
   logic                               m_err;
   logic                               owner;
   logic                               busy;
   logic                               psel;
   logic                               penable;
   logic                               pwrite;
   logic [ADDR_W-1:0]                  paddr;
   logic [DATA_W-1:0]                  pwdata;
   logic [DATA_W-1:0]                  prdata;
   logic                               pready;
   logic                               pslverr;

   modport master (
      input  m_req, m_write, m_addr, m_wdata, prdata, pready, pslverr,
      output m_done, m_rdata, m_err, owner, busy, psel, penable, pwrite, paddr, pwdata
   );

   modport slave (
      output m_req, m_write, m_addr, m_wdata, prdata, pready, pslverr,
      input  m_done, m_rdata, m_err, owner, busy, psel, penable, pwrite, paddr, pwdata
   );
endinterface

// File: rtl/apb_rr_arbiter.sv
// Combinational 2-way round-robin pick: a lone requester wins outright,
// a tie goes to the master that did not own the previous transfer.
module apb_rr_arbiter
   import apb_master_arbiter_pkg::*;
(
   input  logic [NUM_MASTERS-1:0] i_eligible,
   input  logic                   i_last_grant,
   output logic [NUM_MASTERS-1:0] o_gnt,
   output logic                   o_gnt_valid
);
   always_comb begin
      o_gnt = '0;
      case (i_eligible)
         2'b01:   o_gnt = 2'b01;
         2'b10:   o_gnt = 2'b10;
         2'b11:   o_gnt = i_last_grant ? 2'b01 : 2'b10;
         default: o_gnt = '0;
      endcase
   end

   assign o_gnt_valid = |i_eligible;
endmodule

// File: rtl/apb_master_arbiter.sv
// Two-master APB arbiter: round-robin grant, SETUP/ACCESS sequencing, PREADY wait
// states and a wait-state timeout that force-completes a hung transfer with an error.
module apb_master_arbiter
   import apb_master_arbiter_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16,
   parameter int TO_W    = 5
)(
   input  logic                 i_hclk,
   input  logic                 i_hrstn,
   apb_master_arbiter_if.master bus
);
   localparam int              TO_LAST_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
   localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TO_LAST_I);

   apb_state_t             r_state;
   logic [TO_W-1:0]        r_wcnt;
   logic                   r_last_grant;
   logic                   r_owner;
   logic                   r_psel;
   logic                   r_penable;
   logic                   r_pwrite;
   logic [ADDR_W-1:0]      r_paddr;
   logic [DATA_W-1:0]      r_pwdata;
   logic [NUM_MASTERS-1:0] r_done;
   logic [DATA_W-1:0]      r_rdata;
   logic                   r_err;

   logic [NUM_MASTERS-1:0] w_eligible;
   logic [NUM_MASTERS-1:0] w_gnt;
   logic                   w_gnt_valid;
   logic                   w_win;
   logic                   w_timeout;

   // A master still seeing its own done pulse is dropping m_req; don't re-grant it.
   assign w_eligible = bus.m_req & ~r_done;
   assign w_win      = w_gnt[1];
   assign w_timeout  = (TIMEOUT != 0) && !bus.pready && (r_wcnt == TO_LAST);

   apb_rr_arbiter u_rr (
      .i_eligible   (w_eligible),
      .i_last_grant (r_last_grant),
      .o_gnt        (w_gnt),
      .o_gnt_valid  (w_gnt_valid)
   );

   always_ff @(posedge i_hclk or negedge i_hrstn) begin
      if (!i_hrstn) begin
         r_state      <= ST_IDLE;
         r_wcnt       <= '0;
         r_last_grant <= 1'b1;
         r_owner      <= 1'b0;
         r_psel       <= 1'b0;
         r_penable    <= 1'b0;
         r_pwrite     <= 1'b0;
         r_paddr      <= '0;
         r_pwdata     <= '0;
         r_done       <= '0;
         r_rdata      <= '0;
         r_err        <= 1'b0;
      end else begin
         // Completion outputs are single-cycle pulses.
         r_done  <= '0;
         r_rdata <= '0;
         r_err   <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_gnt_valid) begin
                  r_owner   <= w_win;
                  r_paddr   <= bus.m_addr[w_win];
                  r_pwrite  <= bus.m_write[w_win];
                  r_pwdata  <= bus.m_write[w_win] ? bus.m_wdata[w_win] : '0;
                  r_psel    <= 1'b1;
                  r_penable <= 1'b0;
                  r_state   <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               r_penable <= 1'b1;
               r_wcnt    <= '0;
               r_state   <= ST_ACCESS;
            end
            ST_ACCESS: begin
               if (bus.pready || w_timeout) begin
                  r_done[r_owner] <= 1'b1;
                  r_rdata         <= (bus.pready && !r_pwrite) ? bus.prdata : '0;
                  r_err           <= bus.pready ? bus.pslverr : 1'b1;
                  r_psel          <= 1'b0;
                  r_penable       <= 1'b0;
                  r_last_grant    <= r_owner;
                  r_state         <= ST_IDLE;
               end else begin
                  r_wcnt <= r_wcnt + TO_W'(1);
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.m_done  = r_done;
   assign bus.m_rdata = r_rdata;
   assign bus.m_err   = r_err;
   assign bus.owner   = r_owner;
   assign bus.busy    = r_psel;
   assign bus.psel    = r_psel;
   assign bus.penable = r_penable;
   assign bus.pwrite  = r_pwrite;
   assign bus.paddr   = r_paddr;
   assign bus.pwdata  = r_pwdata;
endmodule
